// File: rtl/instr_encoder.sv
// Streaming RV32 instruction encoder: turns field-level requests into 32-bit words with addresses.
// Optional macro ENC_RANGE_CHECK_EN rejects out-of-range or misaligned immediates as NOP.
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_word_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              done_o,
  output logic [7:0]        err_cnt_o
);

  localparam logic [6:0]        OP_I_ALU = 7'b0010011;
  localparam logic [6:0]        OP_LOAD  = 7'b0000011;
  localparam logic [6:0]        OP_STORE = 7'b0100011;
  localparam logic [6:0]        OP_BRANCH = 7'b1100011;
  localparam logic [6:0]        OP_JAL   = 7'b1101111;
  localparam logic [31:0]       NOP_WORD = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  // Returns {error, word}; any rejected request encodes as NOP.
  function automatic logic [32:0] encode(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [2:0] f3, input logic [31:0] imm);
    logic [31:0] w;
    logic        bad;
    w   = NOP_WORD;
    bad = 1'b0;
    case (op)
      OP_I_ALU, OP_LOAD: begin
        w = {imm[11:0], rs1, f3, rd, op};
`ifdef ENC_RANGE_CHECK_EN
        if ($signed(imm) < -32'sd2048 || $signed(imm) > 32'sd2047) bad = 1'b1;
`endif
      end
      OP_STORE: begin
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
`ifdef ENC_RANGE_CHECK_EN
        if ($signed(imm) < -32'sd2048 || $signed(imm) > 32'sd2047) bad = 1'b1;
`endif
      end
      OP_BRANCH: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
`ifdef ENC_RANGE_CHECK_EN
        if ($signed(imm) < -32'sd4096 || $signed(imm) > 32'sd4094 || imm[0]) bad = 1'b1;
`endif
      end
      OP_JAL: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
`ifdef ENC_RANGE_CHECK_EN
        if ($signed(imm) < -32'sd1048576 || $signed(imm) > 32'sd1048574 || imm[0]) bad = 1'b1;
`endif
      end
      default: bad = 1'b1;
    endcase
    if (bad) w = NOP_WORD;
    return {bad, w};
  endfunction

  state_t              state_q;
  logic                out_valid_q;
  logic [31:0]         out_word_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                done_q;
  logic [7:0]          err_cnt_q;
  logic [32:0]         enc_d;
  logic                accept_s;
  logic                out_hs_s;

  assign enc_d      = encode(opcode_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i);
  assign in_ready_o = (state_q == RUN) && (!out_valid_q || out_ready_i);
  assign accept_s   = in_valid_i && in_ready_o;
  assign out_hs_s   = out_valid_q && out_ready_i;

  assign out_valid_o = out_valid_q;
  assign out_word_o  = out_word_q;
  assign out_addr_o  = out_addr_q;
  assign done_o      = done_q;
  assign err_cnt_o   = err_cnt_q;

  // Sequence FSM with the output register, address counter and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'h0000_0000;
      out_addr_q  <= ADDR_BASE;
      done_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= RUN;
            out_addr_q <= ADDR_BASE;
            err_cnt_q  <= 8'd0;
          end
        end
        RUN: begin
          if (out_hs_s) out_addr_q <= out_addr_q + ADDR_ONE;
          // A new word overwrites the one leaving this cycle, so no bubble appears.
          if (accept_s) begin
            out_valid_q <= 1'b1;
            out_word_q  <= enc_d[31:0];
            if (enc_d[32] && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            if (in_last_i) state_q <= DRAIN;
          end else if (out_hs_s) begin
            out_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_hs_s) begin
            out_addr_q  <= out_addr_q + ADDR_ONE;
            out_valid_q <= 1'b0;
          end
          if (!out_valid_q || out_ready_i) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder with a word/address scoreboard queue.
module tb_instr_encoder;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] exp_word;
    logic        bad;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [7:0]  out_addr;
  logic        done;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;
  vec_t        tbl[$];
  vec_t        seq[$];
  logic [31:0] sb[$];
  logic [7:0]  exp_addr;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
    .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3), .imm_i(imm),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_word_o(out_word),
    .out_addr_o(out_addr), .done_o(done), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                              input logic [4:0] rs2_v, input logic [2:0] f3_v, input logic [31:0] imm_v,
                              input logic [31:0] w, input logic bad);
    vec_t v;
    v.op = op; v.rd = rd_v; v.rs1 = rs1_v; v.rs2 = rs2_v; v.f3 = f3_v; v.imm = imm_v;
    v.exp_word = w; v.bad = bad;
    return v;
  endfunction

  // Starts a sequence, streams seq[] through the DUT and checks words, addresses, done and err_cnt.
  task automatic run_seq(input int stall_start, input int stall_len, input int start_at);
    int          idx = 0;
    int          cyc = 0;
    int          budget;
    int          waited = 0;
    int          nbad = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = 32'd0;
    logic [31:0] e;
    budget = seq.size() * 4 + 50;
    foreach (seq[k]) if (seq[k].bad) nbad++;
    if (nbad > 255) nbad = 255;
    sb.delete();
    exp_addr = 8'd0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while ((idx < seq.size() || sb.size() > 0) && cyc < budget) begin
      in_valid = (idx < seq.size());
      if (idx < seq.size()) begin
        opcode = seq[idx].op; rd = seq[idx].rd; rs1 = seq[idx].rs1; rs2 = seq[idx].rs2;
        funct3 = seq[idx].f3; imm = seq[idx].imm;
        in_last = (idx == seq.size() - 1);
      end else begin
        in_last = 1'b0;
      end
      out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      start = (cyc == start_at);
      #1;
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_word", out_word, prev_word);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_word", out_word, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          check("word", out_word, e);
          check("addr", {24'd0, out_addr}, {24'd0, exp_addr});
          exp_addr = exp_addr + 8'd1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_word;
      if (in_valid && in_ready) begin
        sb.push_back(seq[idx].exp_word);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0; out_ready = 1'b1;
    check("seq_timeout", {31'd0, cyc >= budget}, 32'd0);
    while (!done && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("err_cnt", {24'd0, err_cnt}, nbad);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    // Main table: fields in, expected words out.
    tbl.push_back(mk(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h0000_0013, 1'b1));
    tbl.push_back(mk(7'b0010011, 5'd1, 5'd0, 5'd31, 3'd0, 32'd5, 32'h0050_0093, 1'b0));
    tbl.push_back(mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8, 32'h0020_A423, 1'b0));
    tbl.push_back(mk(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, -32'sd4, 32'hFE00_0EE3, 1'b0));
    tbl.push_back(mk(7'b1101111, 5'd1, 5'd7, 5'd9, 3'b011, 32'd8, 32'h0080_00EF, 1'b0));
    tbl.push_back(mk(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, -32'sd1, 32'hFFF1_2283, 1'b0));
    tbl.push_back(mk(7'b0100011, 5'd0, 5'd3, 5'd4, 3'b000, -32'sd16, 32'hFE41_8823, 1'b0));
    tbl.push_back(mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b001, 32'd16, 32'h0020_9863, 1'b0));
    tbl.push_back(mk(7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, -32'sd8, 32'hFF9F_F06F, 1'b0));
`ifdef ENC_RANGE_CHECK_EN
    tbl.push_back(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096, 32'h0000_0013, 1'b1));
`else
    tbl.push_back(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096, 32'h0000_0093, 1'b0));
`endif

    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_addr", {24'd0, out_addr}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_no_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Full table with a stall in the middle and a stray start while running.
    seq.delete();
    foreach (tbl[i]) seq.push_back(tbl[i]);
    run_seq(4, 3, 2);

    // Four back-to-back words with out_ready held low for the first three cycles.
    seq.delete();
    for (int i = 1; i <= 4; i++) seq.push_back(tbl[i]);
    run_seq(0, 3, -1);

    // Long bad-opcode stream: err_cnt saturates and out_addr wraps.
    seq.delete();
    for (int i = 0; i < 258; i++)
      seq.push_back(mk((i % 2 == 0) ? 7'b0110111 : 7'b1110011, 5'd0, 5'd0, 5'd0, 3'd0, i,
                       32'h0000_0013, 1'b1));
    run_seq(1000, 0, -1);

    // Reset asserted while a word is pending.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opcode = 7'b0110111; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_word", out_word, 32'd0);
    check("midrst_out_addr", {24'd0, out_addr}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, width of the instruction word address counter.
REQ-002 Parameter BASE_ADDR, default 0, address of the first encoded word after start.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a program-encode sequence.
REQ-006 in_valid / in_ready  input / output  1 / 1  request handshake; transfer when both are high.
REQ-007 in_last  input  1  marks the final request of the sequence.
REQ-008 opcode  input  7  supported: 0010011 (I-ALU), 0000011 (I-load), 0100011 (S), 1100011 (B), 1101111 (J).
REQ-009 rd, rs1, rs2  input  5 each  register fields; funct3 input 3; imm input 32 (signed byte offset).
REQ-010 out_valid / out_ready  output / input  1 / 1  encoded-word handshake.
REQ-011 out_word  output  32  encoded instruction; out_addr output ADDR_W word address.
REQ-012 done  output  1  one-cycle pulse at sequence end; err_cnt output 8 saturating error count.

Function
REQ-013 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-014 IDLE: in_ready=0; start -> RUN, out_addr<=BASE_ADDR, err_cnt<=0; start is ignored in every other state.
REQ-015 RUN: in_ready = !out_valid || out_ready; accepting a request with in_last=1 -> DRAIN.
REQ-016 DRAIN: in_ready=0; when the output register is empty, or its handshake occurs, -> DONE.
REQ-017 DONE: done=1 for exactly one cycle -> IDLE.
REQ-018 Latency: out_word/out_valid are registered and valid the cycle after acceptance; throughput is one word per cycle while out_ready=1.
REQ-019 out_valid and out_word hold stable until out_ready; out_addr increments by 1 on each output handshake and wraps modulo 2^ADDR_W.
REQ-020 I-type word = imm[11:0], rs1, funct3, rd, opcode.
REQ-021 S-type word = imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
REQ-022 B-type word = imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
REQ-023 J-type word = imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode; funct3, rs1 and rs2 are ignored.
REQ-024 Unsupported opcode -> out_word=0x00000013 (NOP); err_cnt increments, saturating at 255.
REQ-025 Simultaneous acceptance and output handshake in the same cycle: the new word replaces the old one with no bubble.

Reset
REQ-026 When rst_n is low: state=IDLE, out_valid=0, out_word=0, out_addr=BASE_ADDR, done=0, err_cnt=0, in_ready=0.
REQ-027 Reset asserted mid-sequence discards any pending word; after release, a new start is required.

Configuration
REQ-028 Macro ENC_RANGE_CHECK_EN, when defined: I/S imm outside [-2048,2047], B imm outside [-4096,4094] or odd, or J imm outside [-1048576,1048574] or odd -> out_word=NOP and err_cnt increments.
REQ-029 When ENC_RANGE_CHECK_EN is undefined: no range or alignment check; imm bits are truncated per REQ-020..023; only REQ-024 affects err_cnt.

Verification
REQ-030 start, then addi (opcode 0010011, rd=1, rs1=0, funct3=000, imm=5, in_last=1) -> out_word=0x00500093, out_addr=0 next cycle; done pulses afterwards.
REQ-031 Request sw (opcode 0100011, rs1=1, rs2=2, funct3=010, imm=8) -> 0x0020A423; beq (rs1=0, rs2=0, imm=-4) -> 0xFE000EE3.
REQ-032 Request jal (rd=1, imm=8) -> 0x008000EF; a back-to-back stream of 4 words with out_ready held low for 3 cycles -> no loss or duplication, out_addr 0..3.
REQ-033 Request with opcode 0110111 -> NOP, err_cnt=1; addi with imm=4096 -> NOP and err_cnt=2 with ENC_RANGE_CHECK_EN defined, 0x00000093 without it.
REQ-034 Assert rst_n low while out_valid=1 in RUN -> all outputs take their reset values immediately; start while in RUN has no effect.
